// File: rtl/riscv_run_pkg.sv
// Shared types and constants for the RISC-V run controller.
// The halt-cause priority encoder lives here so the detector and any debug logic agree on it.
package riscv_run_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RESET_HOLD = 2'd1,
    RUN        = 2'd2,
    DONE       = 2'd3
  } run_state_t;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    EBREAK  = 2'd1,
    STALL   = 2'd2,
    TIMEOUT = 2'd3
  } halt_cause_t;

  localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

  // Several halt conditions can fire on one cycle; ebreak wins, then stall, then timeout.
  function automatic halt_cause_t pick_halt_cause(input logic hit_ebreak,
                                                  input logic hit_stall,
                                                  input logic hit_timeout);
    halt_cause_t result;
    result = NONE;
    if (hit_ebreak) begin
      result = EBREAK;
    end else if (hit_stall) begin
      result = STALL;
    end else if (hit_timeout) begin
      result = TIMEOUT;
    end
    return result;
  endfunction

endpackage

// File: rtl/riscv_run_controller_if.sv
// Bundle between the run controller (master) and the core/bench side (slave).
// No handshake: core_retire is a single-cycle qualifier for core_insn; everything else is level.
interface riscv_run_controller_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  import riscv_run_pkg::*;

  logic              start;
  logic [XLEN-1:0]   core_pc;
  logic [31:0]       core_insn;
  logic              core_retire;

  logic              core_reset;
  logic              run_active;
  logic              done;
  logic [1:0]        halt_cause;
  logic [CNT_W-1:0]  cycle_count;
  logic [CNT_W-1:0]  retire_count;
  run_state_t        state;

  modport master (
    input  start, core_pc, core_insn, core_retire,
    output core_reset, run_active, done, halt_cause, cycle_count, retire_count, state
  );

  modport slave (
    output start, core_pc, core_insn, core_retire,
    input  core_reset, run_active, done, halt_cause, cycle_count, retire_count, state
  );

endinterface

// File: rtl/riscv_halt_detect.sv
// Tracks PC repetition and run length while the core runs, and decodes the prioritised halt.
// All history clears whenever run_active is low, so every run starts with no previous PC.
module riscv_halt_detect
  import riscv_run_pkg::*;
#(
  parameter int          XLEN        = 32,
  parameter int          MAX_CYCLES  = 50,
  parameter int          STALL_LIMIT = 8,
  parameter logic [31:0] HALT_INSN   = EBREAK_INSN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run_active,
  input  logic [XLEN-1:0] core_pc,
  input  logic [31:0]     core_insn,
  input  logic            core_retire,
  output logic            halt,
  output halt_cause_t     cause
);

  localparam int SW = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;
  localparam logic [SW-1:0] STALL_LAST = (STALL_LIMIT > 1) ? SW'(STALL_LIMIT - 1) : '0;
  localparam int TW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [TW-1:0] TIME_LAST = TW'(MAX_CYCLES - 1);

  logic [XLEN-1:0] prev_pc;
  logic            prev_valid;
  logic [SW-1:0]   stall_cnt;
  logic [TW-1:0]   run_cnt;

  logic pc_match;
  logic hit_ebreak;
  logic hit_stall;
  logic hit_timeout;

  // run_cnt mirrors cycle_count but never saturates, so a narrow CNT_W cannot hide the timeout.
  always_comb begin
    pc_match    = prev_valid && (core_pc == prev_pc);
    hit_ebreak  = core_retire && (core_insn == HALT_INSN);
    hit_stall   = (STALL_LIMIT != 0) && pc_match && (stall_cnt == STALL_LAST);
    hit_timeout = (run_cnt == TIME_LAST);
    halt        = run_active && (hit_ebreak || hit_stall || hit_timeout);
    cause       = pick_halt_cause(hit_ebreak, hit_stall, hit_timeout);
  end

  always_ff @(posedge clk) begin
    if (reset || !run_active) begin
      prev_pc    <= '0;
      prev_valid <= 1'b0;
      stall_cnt  <= '0;
      run_cnt    <= '0;
    end else begin
      prev_pc    <= core_pc;
      prev_valid <= 1'b1;
      stall_cnt  <= pc_match ? stall_cnt + SW'(1) : '0;
      run_cnt    <= run_cnt + TW'(1);
    end
  end

endmodule

// File: rtl/riscv_run_controller.sv
// Run controller: holds the core in reset, runs it until ebreak, PC stall or timeout, then freezes it.
// Counters and halt cause survive in DONE and are cleared only when a new run enters RESET_HOLD.
module riscv_run_controller
  import riscv_run_pkg::*;
#(
  parameter int          XLEN         = 32,
  parameter int          CNT_W        = 32,
  parameter int          RESET_CYCLES = 4,
  parameter int          MAX_CYCLES   = 50,
  parameter int          STALL_LIMIT  = 8,
  parameter logic [31:0] HALT_INSN    = EBREAK_INSN,
  parameter bit          AUTO_START   = 1'b1
) (
  input logic                    clk,
  input logic                    reset,
  riscv_run_controller_if.master bus
);

  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);

  run_state_t        state;
  run_state_t        state_n;
  logic [HOLD_W-1:0] hold_cnt;
  logic [CNT_W-1:0]  cycle_count;
  logic [CNT_W-1:0]  retire_count;
  halt_cause_t       halt_cause;

  logic        run_active;
  logic        hold_entry;
  logic        halt;
  halt_cause_t det_cause;

  assign run_active = (state == RUN);
  assign hold_entry = (state_n == RESET_HOLD) && (state != RESET_HOLD);

  riscv_halt_detect #(
    .XLEN        (XLEN),
    .MAX_CYCLES  (MAX_CYCLES),
    .STALL_LIMIT (STALL_LIMIT),
    .HALT_INSN   (HALT_INSN)
  ) u_halt_detect (
    .clk         (clk),
    .reset       (reset),
    .run_active  (run_active),
    .core_pc     (bus.core_pc),
    .core_insn   (bus.core_insn),
    .core_retire (bus.core_retire),
    .halt        (halt),
    .cause       (det_cause)
  );

  // AUTO_START only kicks IDLE; a finished run waits for an explicit start.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:       if (AUTO_START || bus.start) state_n = RESET_HOLD;
      RESET_HOLD: if (hold_cnt == HOLD_LAST) state_n = RUN;
      RUN:        if (halt) state_n = DONE;
      DONE:       if (bus.start) state_n = RESET_HOLD;
      default:    state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      cycle_count  <= '0;
      retire_count <= '0;
      halt_cause   <= NONE;
    end else begin
      state    <= state_n;
      hold_cnt <= ((state == RESET_HOLD) && (state_n == RESET_HOLD)) ? hold_cnt + HOLD_W'(1) : '0;
      if (hold_entry) begin
        cycle_count  <= '0;
        retire_count <= '0;
        halt_cause   <= NONE;
      end else if (run_active) begin
        if (!(&cycle_count)) begin
          cycle_count <= cycle_count + CNT_W'(1);
        end
        if (bus.core_retire && !(&retire_count)) begin
          retire_count <= retire_count + CNT_W'(1);
        end
        if (halt) begin
          halt_cause <= det_cause;
        end
      end
    end
  end

  assign bus.core_reset   = (state != RUN);
  assign bus.run_active   = run_active;
  assign bus.done         = (state == DONE);
  assign bus.halt_cause   = halt_cause;
  assign bus.cycle_count  = cycle_count;
  assign bus.retire_count = retire_count;
  assign bus.state        = state;

endmodule

// File: tb/tb_riscv_run_controller.sv
// Bench for riscv_run_controller: four parameter variants share one stimulus stream
// and are checked by directed scenarios plus a randomized run against a phase-level model.
module tb_riscv_run_controller;
  import riscv_run_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int P_IDLE = 0, P_HOLD = 1, P_RUN = 2, P_DONE = 3;
  localparam int     LIM  [4] = '{8, 0, 8, 1};
  localparam int     AUTO [4] = '{1, 1, 0, 1};
  localparam int     MAXC [4] = '{50, 50, 50, 40};
  localparam longint CMAX [4] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        retire = 1'b0;
  logic [31:0] pc = 32'h1000;
  logic [31:0] insn = NOP;

  int tests = 0;
  int fails = 0;

  riscv_run_controller_if #(.XLEN(32), .CNT_W(32)) if0 ();
  riscv_run_controller_if #(.XLEN(32), .CNT_W(32)) if1 ();
  riscv_run_controller_if #(.XLEN(32), .CNT_W(32)) if2 ();
  riscv_run_controller_if #(.XLEN(32), .CNT_W(4))  if3 ();

  riscv_run_controller #(.STALL_LIMIT(8), .AUTO_START(1'b1))
    dut0 (.clk(clk), .reset(rst), .bus(if0));
  riscv_run_controller #(.STALL_LIMIT(0), .AUTO_START(1'b1))
    dut1 (.clk(clk), .reset(rst), .bus(if1));
  riscv_run_controller #(.STALL_LIMIT(8), .AUTO_START(1'b0))
    dut2 (.clk(clk), .reset(rst), .bus(if2));
  riscv_run_controller #(.CNT_W(4), .MAX_CYCLES(40), .STALL_LIMIT(1), .AUTO_START(1'b1))
    dut3 (.clk(clk), .reset(rst), .bus(if3));

  assign if0.start = start; assign if0.core_pc = pc; assign if0.core_insn = insn; assign if0.core_retire = retire;
  assign if1.start = start; assign if1.core_pc = pc; assign if1.core_insn = insn; assign if1.core_retire = retire;
  assign if2.start = start; assign if2.core_pc = pc; assign if2.core_insn = insn; assign if2.core_retire = retire;
  assign if3.start = start; assign if3.core_pc = pc; assign if3.core_insn = insn; assign if3.core_retire = retire;

  logic [3:0]  o_crst, o_run, o_done;
  logic [1:0]  o_cause [4];
  logic [31:0] o_cyc [4];
  logic [31:0] o_ret [4];

  assign o_crst = {if3.core_reset, if2.core_reset, if1.core_reset, if0.core_reset};
  assign o_run  = {if3.run_active, if2.run_active, if1.run_active, if0.run_active};
  assign o_done = {if3.done, if2.done, if1.done, if0.done};
  assign o_cause[0] = if0.halt_cause; assign o_cause[1] = if1.halt_cause;
  assign o_cause[2] = if2.halt_cause; assign o_cause[3] = if3.halt_cause;
  assign o_cyc[0] = if0.cycle_count;  assign o_cyc[1] = if1.cycle_count;
  assign o_cyc[2] = if2.cycle_count;  assign o_cyc[3] = 32'(if3.cycle_count);
  assign o_ret[0] = if0.retire_count; assign o_ret[1] = if1.retire_count;
  assign o_ret[2] = if2.retire_count; assign o_ret[3] = 32'(if3.retire_count);

  // Reference model: a run is a phase plus "how many RUN cycles so far" and
  // "how many samples in a row repeated the previous PC"; a stall halt is the
  // LIM-th such repeat, a timeout is the MAXC-th RUN cycle.
  int          m_phase [4];
  int          m_hold  [4];
  int          m_len   [4];
  int          m_same  [4];
  int          m_cause [4];
  logic [31:0] m_last  [4];
  longint      m_cyc   [4];
  longint      m_ret   [4];
  int          same_n, len_n;

  initial begin
    for (int k = 0; k < 4; k++) begin
      m_phase[k] = P_IDLE; m_hold[k] = 0; m_len[k] = 0; m_same[k] = 0;
      m_cause[k] = 0; m_last[k] = '0; m_cyc[k] = 0; m_ret[k] = 0;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        m_phase[k] <= P_IDLE; m_cyc[k] <= 0; m_ret[k] <= 0; m_cause[k] <= 0;
      end else if ((m_phase[k] == P_IDLE && (AUTO[k] != 0 || start)) ||
                   (m_phase[k] == P_DONE && start)) begin
        m_phase[k] <= P_HOLD; m_hold[k] <= 0;
        m_cyc[k] <= 0; m_ret[k] <= 0; m_cause[k] <= 0;
      end else if (m_phase[k] == P_HOLD) begin
        m_hold[k] <= m_hold[k] + 1;
        if (m_hold[k] + 1 == 4) begin
          m_phase[k] <= P_RUN; m_len[k] <= 0; m_same[k] <= 0;
        end
      end else if (m_phase[k] == P_RUN) begin
        same_n = (m_len[k] > 0 && pc == m_last[k]) ? m_same[k] + 1 : 0;
        len_n  = m_len[k] + 1;
        m_same[k] <= same_n;
        m_len[k]  <= len_n;
        m_last[k] <= pc;
        m_cyc[k]  <= (m_cyc[k] + 1 > CMAX[k]) ? CMAX[k] : m_cyc[k] + 1;
        m_ret[k]  <= (m_ret[k] + longint'(retire) > CMAX[k]) ? CMAX[k] : m_ret[k] + longint'(retire);
        if (retire && insn == EBREAK_INSN) begin
          m_phase[k] <= P_DONE; m_cause[k] <= 1;
        end else if (LIM[k] != 0 && same_n == LIM[k]) begin
          m_phase[k] <= P_DONE; m_cause[k] <= 2;
        end else if (len_n == MAXC[k]) begin
          m_phase[k] <= P_DONE; m_cause[k] <= 3;
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_run(input int k, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      pc = pc + 32'd4;
      tick();
      ok = o_run[k];
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; retire = 1'b0; insn = NOP;
    repeat (3) tick();
    for (int k = 0; k < 4; k++) begin
      tests++;
      if ({o_crst[k], o_run[k], o_done[k], o_cause[k], o_cyc[k], o_ret[k]} !== {3'b100, 2'd0, 32'd0, 32'd0}) begin
        fails++;
        $display("FAIL reset dut%0d: got %h want %h", k,
                 {o_crst[k], o_run[k], o_done[k], o_cause[k], o_cyc[k], o_ret[k]}, {3'b100, 2'd0, 64'd0});
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    rst = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      pc = pc + 32'd4;
      tick();
      tests++;
      if (o_crst[0] !== (e < 5)) begin
        fails++;
        $display("FAIL hold_len edge%0d: core_reset %b want %b", e, o_crst[0], (e < 5));
      end
    end
    n = 0;
    while (!o_done[0] && n < 100) begin
      pc = pc + 32'd4;
      tick();
      n++;
    end
    for (int k = 0; k < 2; k++) begin
      tests++;
      if ({o_done[k], o_crst[k], o_cause[k], o_cyc[k], o_ret[k]} !== {2'b11, 2'd3, 32'd50, 32'd0}) begin
        fails++;
        $display("FAIL timeout dut%0d: done/crst/cause/cyc/ret %b %b %0d %0d %0d want 1 1 3 50 0",
                 k, o_done[k], o_crst[k], o_cause[k], o_cyc[k], o_ret[k]);
      end
    end
    tests++;
    if ({o_crst[2], o_run[2], o_done[2]} !== 3'b100) begin
      fails++;
      $display("FAIL no_auto_start: crst/run/done %b%b%b want 100", o_crst[2], o_run[2], o_done[2]);
    end
    tests++;
    if ({o_done[3], o_cause[3], o_cyc[3]} !== {1'b1, 2'd3, 32'd15}) begin
      fails++;
      $display("FAIL saturate dut3: done %b cause %0d cyc %0d want 1 3 15", o_done[3], o_cause[3], o_cyc[3]);
    end
  endtask

  task automatic test_ebreak();
    bit ok;
    int n;
    pulse_start();
    wait_run(0, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL ebreak_wait_run: run_active %b want 1", o_run[0]); end
    n = 0;
    while (!o_done[0] && n < 60) begin
      n++;
      pc = pc + 32'd4;
      retire = 1'b1;
      insn = (n == 10) ? EBREAK_INSN : NOP;
      start = (n == 5);
      tick();
    end
    retire = 1'b0; insn = NOP; start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tests++;
      if ({o_done[k], o_cause[k], o_cyc[k], o_ret[k]} !== {1'b1, 2'd1, 32'd10, 32'd10}) begin
        fails++;
        $display("FAIL ebreak dut%0d: done %b cause %0d cyc %0d ret %0d want 1 1 10 10",
                 k, o_done[k], o_cause[k], o_cyc[k], o_ret[k]);
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    int n;
    int done_at [4];
    for (int k = 0; k < 4; k++) done_at[k] = 0;
    pulse_start();
    wait_run(0, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL stall_wait_run: run_active %b want 1", o_run[0]); end
    n = 0;
    while (!o_done[1] && n < 70) begin
      n++;
      pc = (n < 5) ? pc + 32'd4 : 32'h40;
      tick();
      for (int k = 0; k < 4; k++) if (o_done[k] && done_at[k] == 0) done_at[k] = n;
    end
    for (int k = 0; k < 4; k++) begin
      int want_n, want_c;
      want_n = (k == 1) ? 50 : (k == 3) ? 6 : 13;
      want_c = (k == 1) ? 3 : 2;
      tests++;
      if (done_at[k] != want_n || o_cause[k] !== 2'(want_c) || o_cyc[k] !== 32'(want_n)) begin
        fails++;
        $display("FAIL stall dut%0d: halted at %0d cause %0d cyc %0d want %0d %0d %0d",
                 k, done_at[k], o_cause[k], o_cyc[k], want_n, want_c, want_n);
      end
    end
  endtask

  task automatic test_priority();
    bit ok;
    pc = 32'h2000;
    pulse_start();
    wait_run(0, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL prio_wait_run: run_active %b want 1", o_run[0]); end
    for (int n = 1; n <= 50; n++) begin
      pc = (n < 42) ? pc + 32'd4 : 32'h80;
      retire = (n == 50);
      insn = (n == 50) ? EBREAK_INSN : NOP;
      tick();
    end
    retire = 1'b0; insn = NOP;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if ({o_done[k], o_cause[k], o_cyc[k], o_ret[k]} !== {1'b1, 2'd1, 32'd50, 32'd1}) begin
        fails++;
        $display("FAIL priority dut%0d: done %b cause %0d cyc %0d ret %0d want 1 1 50 1",
                 k, o_done[k], o_cause[k], o_cyc[k], o_ret[k]);
      end
    end
  endtask

  task automatic test_rerun();
    bit ok;
    int n;
    for (int r = 0; r < 2; r++) begin
      pulse_start();
      tests++;
      if ({o_cyc[2], o_ret[2], o_cause[2]} !== {64'd0, 2'd0}) begin
        fails++;
        $display("FAIL rerun_clear round%0d: cyc %0d ret %0d cause %0d want 0 0 0", r, o_cyc[2], o_ret[2], o_cause[2]);
      end
      wait_run(2, ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL rerun_wait_run round%0d: run_active %b want 1", r, o_run[2]); end
      n = 0;
      while (!o_done[2] && n < 30) begin
        n++;
        pc = pc + 32'd4;
        retire = n[0];
        insn = (n == 7) ? EBREAK_INSN : NOP;
        tick();
      end
      retire = 1'b0; insn = NOP;
      repeat (3) tick();
      tests++;
      if ({o_done[2], o_crst[2], o_cause[2], o_cyc[2], o_ret[2]} !== {2'b11, 2'd1, 32'd7, 32'd4}) begin
        fails++;
        $display("FAIL rerun round%0d: done %b crst %b cause %0d cyc %0d ret %0d want 1 1 1 7 4",
                 r, o_done[2], o_crst[2], o_cause[2], o_cyc[2], o_ret[2]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    pulse_start();
    wait_run(0, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL midrst_wait_run: run_active %b want 1", o_run[0]); end
    retire = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      pc = pc + 32'd4;
      tick();
    end
    rst = 1'b1;
    pc = pc + 32'd4;
    tick();
    rst = 1'b0;
    retire = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tests++;
      if ({o_crst[k], o_run[k], o_done[k], o_cause[k], o_cyc[k], o_ret[k]} !== {3'b100, 2'd0, 32'd0, 32'd0}) begin
        fails++;
        $display("FAIL mid_run_reset dut%0d: crst %b run %b done %b cause %0d cyc %0d ret %0d want 1 0 0 0 0 0",
                 k, o_crst[k], o_run[k], o_done[k], o_cause[k], o_cyc[k], o_ret[k]);
      end
    end
    for (int e = 1; e <= 5; e++) begin
      pc = pc + 32'd4;
      tick();
      if (e >= 4) begin
        tests++;
        if ({o_run[0], o_crst[2]} !== {(e == 5), 1'b1}) begin
          fails++;
          $display("FAIL restart edge%0d: dut0 run %b dut2 crst %b want %b 1", e, o_run[0], o_crst[2], (e == 5));
        end
      end
    end
  endtask

  task automatic test_random();
    int pc_mode;
    logic [70:0] act, exp;
    pc_mode = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 24) == 0) pc_mode = $urandom_range(0, 2);
      case (pc_mode)
        0:       pc = pc + 32'd4;
        1:       pc = pc;
        default: pc = 32'($urandom_range(0, 1)) * 32'd4;
      endcase
      rst    = ($urandom_range(0, 299) == 0);
      start  = ($urandom_range(0, 15) == 0);
      retire = $urandom_range(0, 1) != 0;
      insn   = ($urandom_range(0, 40) == 0) ? EBREAK_INSN : $urandom;
      tick();
      for (int k = 0; k < 4; k++) begin
        act = {o_crst[k], o_run[k], o_done[k], o_cause[k], o_cyc[k], o_ret[k]};
        exp = {m_phase[k] != P_RUN, m_phase[k] == P_RUN, m_phase[k] == P_DONE,
               2'(m_cause[k]), 32'(m_cyc[k]), 32'(m_ret[k])};
        tests++;
        if (act !== exp) begin
          fails++;
          $display("FAIL random c%0d dut%0d: got %h want %h", c, k, act, exp);
        end
      end
    end
    rst = 1'b0; start = 1'b0; retire = 1'b0; insn = NOP;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_timeout();
    test_ebreak();
    test_stall();
    test_priority();
    test_rerun();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
